// File: rtl/led_pkg.sv
// Shared constants and types for the LED level meter: display modes, peak FSM states
// and a counter-width helper. No logic, no latency, no flow control.
package led_pkg;

  localparam logic [1:0] MODE_BAR      = 2'b00;
  localparam logic [1:0] MODE_DOT      = 2'b01;
  localparam logic [1:0] MODE_BAR_PEAK = 2'b10;
  localparam logic [1:0] MODE_BLANK    = 2'b11;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    FALL  = 2'd2
  } peak_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/therm_decode.sv
// Level code to thermometer: bit i set for every i <= level. Purely combinational,
// zero latency, no flow control.
module therm_decode #(
  parameter int LEVEL_W = 4
) (
  input  logic [LEVEL_W-1:0]      level,
  output logic [(2**LEVEL_W)-1:0] therm
);

  localparam int N_LED = 2**LEVEL_W;

  always_comb begin
    therm = '0;
    for (int i = 0; i < N_LED; i++) begin
      therm[i] = (LEVEL_W'(i) <= level);
    end
  end

endmodule

// File: rtl/led_bar_meter.sv
// N-LED level meter with instant attack, timed release, peak-hold marker and display modes.
// led is registered one cycle behind disp/peak/mode; freeze stalls every register, rst overrides it.
module led_bar_meter
  import led_pkg::*;
#(
  parameter int LEVEL_W      = 4,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int DECAY_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LEVEL_W-1:0]      level,
  input  logic [1:0]              mode,
  input  logic                    freeze,
  output logic [(2**LEVEL_W)-1:0] led,
  output logic [LEVEL_W-1:0]      peak
);

  localparam int N_LED = 2**LEVEL_W;
  localparam int HCW   = cnt_w(HOLD_CYCLES);
  localparam int DCW   = cnt_w(DECAY_CYCLES);

  logic [LEVEL_W-1:0] disp_q, disp_d, tgt_q, tgt_d, peak_q, peak_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d, pcnt_q, pcnt_d;
  logic [HCW-1:0]     hcnt_q, hcnt_d;
  peak_state_t        state_q, state_d;
  logic [N_LED-1:0]   led_q, led_d;
  logic [N_LED-1:0]   bar_therm, peak_therm, bar_onehot, peak_onehot;

  therm_decode #(.LEVEL_W(LEVEL_W)) u_bar_therm (
    .level (disp_q),
    .therm (bar_therm)
  );

  therm_decode #(.LEVEL_W(LEVEL_W)) u_peak_therm (
    .level (peak_q),
    .therm (peak_therm)
  );

  // The top set bit of a thermometer is the only bit whose upper neighbour is clear.
  assign bar_onehot  = bar_therm  & ~(bar_therm  >> 1);
  assign peak_onehot = peak_therm & ~(peak_therm >> 1);

  always_comb begin
    tgt_d  = tgt_q;
    disp_d = disp_q;
    dcnt_d = dcnt_q;
    if (in_valid) tgt_d = level;

    // Release compares against the incoming target so a fresh sample is never undershot.
    if (in_valid && (level > disp_q)) begin
      disp_d = level;
      dcnt_d = '0;
    end else if (disp_q > tgt_d) begin
      if (dcnt_q == DCW'(DECAY_CYCLES - 1)) begin
        disp_d = disp_q - 1'b1;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end else begin
      dcnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    hcnt_d  = hcnt_q;
    pcnt_d  = pcnt_q;
    if (disp_d > peak_q) begin
      peak_d  = disp_d;
      hcnt_d  = '0;
      pcnt_d  = '0;
      state_d = HOLD;
    end else begin
      case (state_q)
        TRACK: peak_d = disp_d;
        HOLD: begin
          if (hcnt_q == HCW'(HOLD_CYCLES - 1)) begin
            hcnt_d  = '0;
            pcnt_d  = '0;
            state_d = FALL;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        FALL: begin
          if (peak_q == disp_d) begin
            pcnt_d  = '0;
            state_d = TRACK;
          end else if (pcnt_q == DCW'(DECAY_CYCLES - 1)) begin
            peak_d = peak_q - 1'b1;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        default: state_d = TRACK;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (mode)
      MODE_BAR:      led_d = bar_therm;
      MODE_DOT:      led_d = bar_onehot;
      MODE_BAR_PEAK: led_d = bar_therm | peak_onehot;
      default:       led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q  <= '0;
      tgt_q   <= '0;
      peak_q  <= '0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      state_q <= TRACK;
      led_q   <= N_LED'(1);
    end else if (!freeze) begin
      disp_q  <= disp_d;
      tgt_q   <= tgt_d;
      peak_q  <= peak_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign peak = peak_q;

endmodule
